ahb_decode_mux: RTL and testbench
=================================

// Module: ahb_decode_mux
// PURPOSE
// Parametrised AHB-Lite decoder/multiplexor between one manager and NSAT satellites.
// Address map set by per-satellite BASE/MASK parameters. Unmapped accesses go to a built-in default
// satellite that returns a two-cycle ERROR response. Optional watchdog converts a satellite hung in
// wait states into an ERROR. Replaces fixed-map muxes at the top of the SoC bus.
// PARAMETERS
// NSAT      4                        number of external satellites (1..16)
// SAT_BASE  {NSAT{32'h0}}            packed NSAT*32; base address of satellite i in bits [32i+:32]
// SAT_MASK  {NSAT{32'hFFFF_0000}}    packed NSAT*32; satellite i matches when (haddr&MASK)==BASE
// TO_CYC    256                      watchdog limit, consecutive wait cycles (>=2); only with macro
// PORTS
// clk          in   1        clock
// nrst         in   1        synchronous active-low reset
// m_haddr      in   32       manager address; broadcast to all satellites
// m_htrans     in   2        manager htrans; broadcast
// m_hwrite     in   1        manager hwrite; broadcast
// m_hsize      in   3        manager hsize; broadcast
// m_hburst     in   3        manager hburst; broadcast
// m_hwdata     in   32       manager write data; broadcast
// m_hrdata     out  32       read data muxed from data-phase satellite
// m_hready     out  1        bus hready to manager; also driven to every s_hready
// m_hresp      out  1        response muxed from data-phase satellite
// s_hsel       out  NSAT     one-hot address-phase select
// s_hready     out  NSAT     copy of m_hready per satellite
// s_hrdata     in   NSAT*32  satellite read data
// s_hreadyout  in   NSAT     satellite readyout
// s_hresp      in   NSAT     satellite response
// dec_err      out  1        1-cycle pulse when a default-satellite ERROR starts
// to_err       out  1        1-cycle pulse when watchdog ERROR starts (0 without macro)
// BEHAVIOUR
// - Address phase is combinational: active = m_htrans[1] (NONSEQ/SEQ).
//   Satellite i matches when active & (m_haddr&MASK_i)==BASE_i; lowest matching i wins; s_hsel one-hot or 0.
// - IDLE/BUSY: no s_hsel. The default satellite answers with OKAY and zero waits.
// - Data-phase select: reg sel_q (index plus def flag) loads the address-phase decision only when m_hready=1.
//   Reset value: def, idle.
// - Data phase on satellite: m_hrdata/m_hresp/m_hready come from s_*[sel_q].
//   The satellite's wait states pass through unchanged.
// - Default satellite FSM: D_IDLE, D_ERR1, D_ERR2.
//   D_IDLE -> D_ERR1 when an active unmapped transfer is latched.
//   D_ERR1: hready=0, hresp=1, pulse dec_err. Always -> D_ERR2.
//   D_ERR2: hready=1, hresp=1. -> D_ERR1 if another active unmapped transfer is latched, else D_IDLE.
//   m_hrdata = 0 in all default states.
// - Back-to-back mapped transfers have 0 added latency. An unmapped transfer costs exactly 2 data cycles.
// - A transfer whose address phase overlaps D_ERR1 is not latched (m_hready=0).
//   The manager holds its address, per AHB.
// - Reset: synchronous and takes priority over everything, including mid-wait and mid-ERROR.
//   Next cycle: FSMs idle, sel_q=def, m_hready=1, m_hresp=0, m_hrdata=0.
//   s_hsel still follows the combinational decode.
// - Outputs are never X: an out-of-range sel_q falls back to the default satellite.
// CONFIGURATION
// - AHB_DECODE_MUX_TIMEOUT_EN defined: 9-bit+ counter wcnt counts consecutive cycles with a satellite
//   in data phase and s_hreadyout=0. It clears when hreadyout=1 or the satellite changes.
//   When wcnt reaches TO_CYC-1, FSM T_ERR1 (hready=0, hresp=1, pulse to_err) then T_ERR2
//   (hready=1, hresp=1). The hung satellite's signals are ignored during both states.
//   sel_q then reloads normally.
// - Not defined: no counter, no T_* states, to_err tied 0, and wait states can last indefinitely.
// TESTING
// - NSAT=4, BASE0=0x0, read 0x0000_0010 with s_hreadyout[0]=1 -> s_hsel=0001, next cycle
//   m_hrdata=s_hrdata[0], m_hresp=0.
// - Write 0x0009_0000 (unmapped) -> m_hready 0 then 1, m_hresp 1,1, dec_err pulses once;
//   the next NONSEQ is latched on the ERR2 edge.
// - Overlapping masks, BASE1=BASE2=0x0002_0000 -> s_hsel=0010 (lowest index wins).
// - Satellite 2 holds hreadyout=0 for 3 cycles -> m_hready=0 for exactly 3 cycles,
//   the next address is not forwarded early.
// - Macro on, TO_CYC=8, satellite 3 stuck -> to_err pulses on the 8th wait cycle,
//   then the 2-cycle ERROR, then the bus recovers.
// - nrst low during D_ERR1 -> next cycle m_hready=1, m_hresp=0, dec_err=0.

Source files
------------

// File: rtl/ahb_decode_mux.sv
// rtl/ahb_decode_mux.sv - AHB-Lite decoder/multiplexor, one manager to NSAT satellites plus default error satellite
// Optional wait-state watchdog enabled by defining AHB_DECODE_MUX_TIMEOUT_EN.
module ahb_decode_mux #(
  parameter int                 NSAT     = 4,
  parameter logic [NSAT*32-1:0] SAT_BASE = {NSAT{32'h0}},
  parameter logic [NSAT*32-1:0] SAT_MASK = {NSAT{32'hFFFF_0000}},
  parameter int                 TO_CYC   = 256
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [31:0]          m_haddr,
  input  logic [1:0]           m_htrans,
  input  logic                 m_hwrite,
  input  logic [2:0]           m_hsize,
  input  logic [2:0]           m_hburst,
  input  logic [31:0]          m_hwdata,
  output logic [31:0]          m_hrdata,
  output logic                 m_hready,
  output logic                 m_hresp,
  output logic [NSAT-1:0]      s_hsel,
  output logic [NSAT-1:0]      s_hready,
  input  logic [NSAT*32-1:0]   s_hrdata,
  input  logic [NSAT-1:0]      s_hreadyout,
  input  logic [NSAT-1:0]      s_hresp,
  output logic                 dec_err,
  output logic                 to_err
);

  localparam int IW = (NSAT > 1) ? $clog2(NSAT) : 1;

  typedef enum logic [2:0] {
    D_IDLE = 3'd0,
    D_ERR1 = 3'd1,
    D_ERR2 = 3'd2
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
    , T_ERR1 = 3'd3
    , T_ERR2 = 3'd4
`endif
  } state_e;

  state_e        state_q;
  logic          err_ready_q;
  logic          err_resp_q;
  logic          dec_err_q;
  logic [IW-1:0] idx_q;
  logic          def_q;

  logic          active;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          unm_lat;

  logic          sat_ok;
  logic          sat_ready;
  logic          sat_resp;
  logic [31:0]   sat_rdata;

  // Control/data inputs that are only broadcast to satellites, never decoded here.
  logic unused_ok;
  assign unused_ok = ^{m_htrans[0], m_hwrite, m_hsize, m_hburst, m_hwdata};

  assign active = m_htrans[1];

  // Descending scan so the lowest matching index is the last to overwrite.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    s_hsel  = '0;
    for (int i = NSAT - 1; i >= 0; i--) begin
      if (active && ((m_haddr & SAT_MASK[32*i +: 32]) == SAT_BASE[32*i +: 32])) begin
        hit       = 1'b1;
        hit_idx   = IW'(i);
        s_hsel    = '0;
        s_hsel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sat_ok    = 1'b0;
    sat_ready = 1'b1;
    sat_resp  = 1'b0;
    sat_rdata = '0;
    for (int i = 0; i < NSAT; i++) begin
      if (idx_q == IW'(i)) begin
        sat_ok    = 1'b1;
        sat_ready = s_hreadyout[i];
        sat_resp  = s_hresp[i];
        sat_rdata = s_hrdata[32*i +: 32];
      end
    end
  end

  // Error states own the bus; otherwise a valid satellite index drives it, else the idle default.
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = 1'b0;
    m_hrdata = '0;
    if (state_q != D_IDLE) begin
      m_hready = err_ready_q;
      m_hresp  = err_resp_q;
    end else if (!def_q && sat_ok) begin
      m_hready = sat_ready;
      m_hresp  = sat_resp;
      m_hrdata = sat_rdata;
    end
  end

  assign s_hready = {NSAT{m_hready}};
  assign unm_lat  = m_hready && active && !hit;
  assign dec_err  = dec_err_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      def_q <= 1'b1;
      idx_q <= '0;
    end else if (m_hready) begin
      def_q <= !(active && hit);
      idx_q <= hit_idx;
    end
  end

`ifdef AHB_DECODE_MUX_TIMEOUT_EN
  localparam int WW = ($clog2(TO_CYC + 1) > 9) ? $clog2(TO_CYC + 1) : 9;

  logic [WW-1:0] wcnt_q;
  logic          to_err_q;
  logic          sat_wait;

  assign sat_wait = (state_q == D_IDLE) && !def_q && sat_ok && !sat_ready;
  assign to_err   = to_err_q;
`else
  assign to_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= D_IDLE;
      err_ready_q <= 1'b1;
      err_resp_q  <= 1'b0;
      dec_err_q   <= 1'b0;
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
      to_err_q    <= 1'b0;
      wcnt_q      <= '0;
`endif
    end else begin
      dec_err_q <= 1'b0;
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
      to_err_q  <= 1'b0;
      wcnt_q    <= '0;
`endif
      case (state_q)
        D_ERR1: begin
          state_q     <= D_ERR2;
          err_ready_q <= 1'b1;
          err_resp_q  <= 1'b1;
        end
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
        T_ERR1: begin
          state_q     <= T_ERR2;
          err_ready_q <= 1'b1;
          err_resp_q  <= 1'b1;
        end
`endif
        // D_IDLE and both second ERROR cycles accept a new transfer.
        default: begin
          if (unm_lat) begin
            state_q     <= D_ERR1;
            err_ready_q <= 1'b0;
            err_resp_q  <= 1'b1;
            dec_err_q   <= 1'b1;
          end
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
          else if (sat_wait && (wcnt_q == WW'(TO_CYC - 2))) begin
            state_q     <= T_ERR1;
            err_ready_q <= 1'b0;
            err_resp_q  <= 1'b1;
            to_err_q    <= 1'b1;
          end else if (sat_wait) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
          else begin
            state_q     <= D_IDLE;
            err_ready_q <= 1'b1;
            err_resp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// tb/tb_ahb_decode_mux.sv - scoreboard bench for ahb_decode_mux
// Exercises the watchdog path when AHB_DECODE_MUX_TIMEOUT_EN is defined.
module tb_ahb_decode_mux;
  localparam int NSAT = 4;
  localparam logic [NSAT*32-1:0] BASE = {32'h0004_0000, 32'h0002_0000, 32'h0002_0000, 32'h0000_0000};
  localparam logic [NSAT*32-1:0] MASK = {32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

  logic              clk, nrst;
  logic [31:0]       m_haddr, m_hwdata, m_hrdata;
  logic [1:0]        m_htrans;
  logic              m_hwrite, m_hready, m_hresp, dec_err, to_err;
  logic [2:0]        m_hsize, m_hburst;
  logic [NSAT-1:0]   s_hsel, s_hready, s_hreadyout, s_hresp;
  logic [NSAT*32-1:0] s_hrdata;
  logic [31:0]       sat_val [NSAT];

  typedef struct packed { logic [31:0] rdata; logic resp; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;

  ahb_decode_mux #(.NSAT(NSAT), .SAT_BASE(BASE), .SAT_MASK(MASK), .TO_CYC(8)) dut (
    .clk(clk), .nrst(nrst), .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hrdata(m_hrdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .s_hsel(s_hsel), .s_hready(s_hready),
    .s_hrdata(s_hrdata), .s_hreadyout(s_hreadyout), .s_hresp(s_hresp),
    .dec_err(dec_err), .to_err(to_err));

  assign s_hrdata = {sat_val[3], sat_val[2], sat_val[1], sat_val[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent view of the map: sat1 shadows sat2 in 0x0002_xxxx.
  function automatic int ref_dec(input logic [31:0] a);
    case (a[31:16])
      16'h0000: return 0;
      16'h0002: return 1;
      16'h0003: return 2;
      16'h0004: return 3;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [3:0] ref_sel(input logic [31:0] a);
    logic [3:0] r;
    int i;
    r = '0;
    i = ref_dec(a);
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  function automatic void push(input logic [31:0] a);
    exp_t x;
    int i;
    i = ref_dec(a);
    x.rdata = (i < 0) ? 32'h0 : sat_val[i];
    x.resp  = (i < 0);
    exp_q.push_back(x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w);
    m_haddr  = a;
    m_htrans = t;
    m_hwrite = w;
    m_hwdata = a ^ 32'h5555_5555;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(32'h0002_0010, NONSEQ, 1'b0);
    tick(); tick();
    smp();
    n_chk++; if (s_hsel !== 4'b0010) $display("FAIL rst_hsel got %b want 0010", s_hsel); else n_pass++;
    n_chk++;
    if ({m_hready, m_hresp, dec_err, to_err, s_hready, m_hrdata} !== {4'b1000, 4'b1111, 32'h0})
      $display("FAIL rst_out got rdy=%b resp=%b de=%b te=%b shr=%b rd=%h want 1 0 0 0 1111 0",
               m_hready, m_hresp, dec_err, to_err, s_hready, m_hrdata);
    else n_pass++;
    tick();
    nrst = 1'b1;
    drive(32'h0, IDLE, 1'b0);
    smp();
    n_chk++;
    if ({s_hsel, m_hready, m_hresp} !== 6'b0000_10)
      $display("FAIL idle_okay got hsel=%b rdy=%b resp=%b want 0000 1 0", s_hsel, m_hready, m_hresp);
    else n_pass++;
  endtask

  task automatic test_read();
    tick();
    drive(32'h0000_0010, NONSEQ, 1'b0);
    smp();
    n_chk++; if (s_hsel !== 4'b0001) $display("FAIL read_hsel got %b want 0001", s_hsel); else n_pass++;
    push(m_haddr);
    tick();
    drive(32'h0, IDLE, 1'b0);
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp} !== {1'b1, e.rdata, e.resp})
      $display("FAIL read_data got rdy=%b rd=%h resp=%b want 1 %h %b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    addrs = '{32'h0000_0010, 32'h0002_0000, 32'h0003_0004, 32'h0004_0000, 32'h0002_0004};
    sat_val[1] = 32'h1357_9BDF;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k < 5) drive(addrs[k], (k == 0) ? NONSEQ : SEQ, k[0]);
      else       drive(32'h0, IDLE, 1'b0);
      smp();
      if (k > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({m_hready, m_hrdata, m_hresp} !== {1'b1, e.rdata, e.resp})
          $display("FAIL b2b_data[%0d] got rdy=%b rd=%h resp=%b want 1 %h %b",
                   k - 1, m_hready, m_hrdata, m_hresp, e.rdata, e.resp);
        else n_pass++;
      end
      if (k < 5) begin
        n_chk++;
        if (s_hsel !== ref_sel(addrs[k]))
          $display("FAIL b2b_hsel[%0d] got %b want %b", k, s_hsel, ref_sel(addrs[k]));
        else n_pass++;
        push(addrs[k]);
      end
    end
  endtask

  task automatic test_unmapped();
    tick();
    drive(32'h0009_0000, NONSEQ, 1'b1);
    smp();
    n_chk++; if (s_hsel !== 4'b0000) $display("FAIL unm_hsel got %b want 0000", s_hsel); else n_pass++;
    push(m_haddr);
    tick();
    drive(32'h0010_0000, NONSEQ, 1'b0);
    smp();
    n_chk++;
    if ({m_hready, m_hresp, dec_err, m_hrdata} !== {3'b011, 32'h0})
      $display("FAIL unm_err1 got rdy=%b resp=%b de=%b rd=%h want 0 1 1 0", m_hready, m_hresp, dec_err, m_hrdata);
    else n_pass++;
    tick();
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, dec_err, m_hrdata, m_hresp} !== {2'b10, e.rdata, e.resp})
      $display("FAIL unm_err2 got rdy=%b de=%b rd=%h resp=%b want 1 0 %h %b",
               m_hready, dec_err, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
    push(m_haddr);
    tick();
    drive(32'h0000_0020, NONSEQ, 1'b0);
    smp();
    n_chk++;
    if ({m_hready, m_hresp, dec_err} !== 3'b011)
      $display("FAIL unm_again got rdy=%b resp=%b de=%b want 0 1 1", m_hready, m_hresp, dec_err);
    else n_pass++;
    tick();
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp} !== {1'b1, e.rdata, e.resp})
      $display("FAIL unm_again2 got rdy=%b rd=%h resp=%b want 1 %h %b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
    push(m_haddr);
    tick();
    drive(32'h0, IDLE, 1'b0);
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp, dec_err} !== {1'b1, e.rdata, e.resp, 1'b0})
      $display("FAIL unm_next got rdy=%b rd=%h resp=%b de=%b want 1 %h %b 0",
               m_hready, m_hrdata, m_hresp, dec_err, e.rdata, e.resp);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    tick();
    drive(32'h0003_0000, NONSEQ, 1'b0);
    smp();
    n_chk++; if (s_hsel !== 4'b0100) $display("FAIL wait_hsel got %b want 0100", s_hsel); else n_pass++;
    push(m_haddr);
    tick();
    s_hreadyout[2] = 1'b0;
    drive(32'h0000_0030, NONSEQ, 1'b0);
    for (int w = 0; w < 3; w++) begin
      smp();
      n_chk++;
      if ({m_hready, s_hready} !== 5'b0_0000)
        $display("FAIL wait_cyc[%0d] got rdy=%b shr=%b want 0 0000", w, m_hready, s_hready);
      else n_pass++;
      tick();
    end
    s_hreadyout[2] = 1'b1;
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp} !== {1'b1, e.rdata, e.resp})
      $display("FAIL wait_done got rdy=%b rd=%h resp=%b want 1 %h %b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
    push(m_haddr);
    tick();
    drive(32'h0, IDLE, 1'b0);
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp} !== {1'b1, e.rdata, e.resp})
      $display("FAIL wait_next got rdy=%b rd=%h resp=%b want 1 %h %b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    tick();
    drive(32'h0004_0000, NONSEQ, 1'b0);
    smp();
    n_chk++; if (s_hsel !== 4'b1000) $display("FAIL wd_hsel got %b want 1000", s_hsel); else n_pass++;
`ifdef AHB_DECODE_MUX_TIMEOUT_EN
    exp_q.push_back('{rdata: 32'h0, resp: 1'b1});
    tick();
    s_hreadyout[3] = 1'b0;
    drive(32'h0000_0040, NONSEQ, 1'b0);
    for (int w = 1; w <= 7; w++) begin
      smp();
      n_chk++;
      if ({m_hready, to_err} !== 2'b00) $display("FAIL wd_wait[%0d] got rdy=%b te=%b want 0 0", w, m_hready, to_err);
      else n_pass++;
      tick();
    end
    smp();
    n_chk++;
    if ({m_hready, m_hresp, to_err} !== 3'b011)
      $display("FAIL wd_terr1 got rdy=%b resp=%b te=%b want 0 1 1", m_hready, m_hresp, to_err);
    else n_pass++;
    tick();
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, to_err, m_hrdata, m_hresp} !== {2'b10, e.rdata, e.resp})
      $display("FAIL wd_terr2 got rdy=%b te=%b rd=%h resp=%b want 1 0 %h %b",
               m_hready, to_err, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
`else
    push(m_haddr);
    tick();
    s_hreadyout[3] = 1'b0;
    drive(32'h0000_0040, NONSEQ, 1'b0);
    for (int w = 1; w <= 20; w++) begin
      smp();
      n_chk++;
      if ({m_hready, to_err} !== 2'b00) $display("FAIL wd_wait[%0d] got rdy=%b te=%b want 0 0", w, m_hready, to_err);
      else n_pass++;
      tick();
    end
    s_hreadyout[3] = 1'b1;
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp} !== {1'b1, e.rdata, e.resp})
      $display("FAIL wd_done got rdy=%b rd=%h resp=%b want 1 %h %b", m_hready, m_hrdata, m_hresp, e.rdata, e.resp);
    else n_pass++;
`endif
    push(m_haddr);
    tick();
    drive(32'h0, IDLE, 1'b0);
    s_hreadyout[3] = 1'b1;
    smp();
    e = exp_q.pop_front();
    n_chk++;
    if ({m_hready, m_hrdata, m_hresp, to_err} !== {1'b1, e.rdata, e.resp, 1'b0})
      $display("FAIL wd_recover got rdy=%b rd=%h resp=%b te=%b want 1 %h %b 0",
               m_hready, m_hrdata, m_hresp, to_err, e.rdata, e.resp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_err();
    tick();
    drive(32'h0009_0000, NONSEQ, 1'b1);
    tick();
    drive(32'h0, IDLE, 1'b0);
    nrst = 1'b0;
    smp();
    n_chk++;
    if ({m_hready, dec_err} !== 2'b01) $display("FAIL rerr_pre got rdy=%b de=%b want 0 1", m_hready, dec_err);
    else n_pass++;
    tick();
    nrst = 1'b1;
    smp();
    n_chk++;
    if ({m_hready, m_hresp, dec_err, m_hrdata} !== {3'b100, 32'h0})
      $display("FAIL rerr_post got rdy=%b resp=%b de=%b rd=%h want 1 0 0 0", m_hready, m_hresp, dec_err, m_hrdata);
    else n_pass++;
    tick();
    smp();
    n_chk++;
    if ({m_hready, m_hresp} !== 2'b10) $display("FAIL rerr_tail got rdy=%b resp=%b want 1 0", m_hready, m_hresp);
    else n_pass++;
  endtask

  initial begin
    sat_val     = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hCCCC_0002, 32'hDDDD_0003};
    s_hreadyout = '1;
    s_hresp     = '0;
    m_hsize     = 3'b010;
    m_hburst    = 3'b000;
    drive(32'h0, IDLE, 1'b0);
    nrst        = 1'b0;
    test_reset();
    test_read();
    test_back_to_back();
    test_unmapped();
    test_wait_states();
    test_watchdog();
    test_reset_mid_err();
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL sb_drain got %0d entries want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no completion want finish before 100us");
    $fatal(1, "timeout");
  end

endmodule
